// File: rtl/one_bit_adder_if.sv
// Operand/result bundle for one full-adder cell.
// master drives the operands; slave is the adder side.
interface one_bit_adder_if;
  logic in1;
  logic in2;
  logic carryin;
  logic sum;
  logic carryout;
  logic prop;
  logic gen;
  logic sum_q;
  logic carryout_q;

  modport master (
    output in1,
    output in2,
    output carryin,
    input  sum,
    input  carryout,
    input  prop,
    input  gen,
    input  sum_q,
    input  carryout_q
  );

  modport slave (
    input  in1,
    input  in2,
    input  carryin,
    output sum,
    output carryout,
    output prop,
    output gen,
    output sum_q,
    output carryout_q
  );
endinterface

// File: rtl/one_bit_adder.sv
// Gate-level full adder cell (two half adders + OR).
// Adds a registered copy of sum/carry for pipelined users.
module one_bit_adder #(
  parameter int GATE_DELAY = 0
) (
  input logic          clk,
  input logic          reset,
  one_bit_adder_if.slave bus
);

  wire p;
  wire g;
  wire s;
  wire pc;
  wire co;

  // First half adder: in1 + in2
  xor #(GATE_DELAY) u_x1 (p, bus.in1, bus.in2);
  and #(GATE_DELAY) u_a1 (g, bus.in1, bus.in2);

  // Second half adder: p + carryin
  xor #(GATE_DELAY) u_x2 (s, p, bus.carryin);
  and #(GATE_DELAY) u_a2 (pc, p, bus.carryin);

  or  #(GATE_DELAY) u_o1 (co, g, pc);

  assign bus.sum      = s;
  assign bus.carryout = co;
  assign bus.prop     = p;
  assign bus.gen      = g;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.sum_q      <= 1'b0;
      bus.carryout_q <= 1'b0;
    end else begin
      bus.sum_q      <= s;
      bus.carryout_q <= co;
    end
  end

endmodule

// File: tb/tb_one_bit_adder.sv
// Directed bench for one_bit_adder.
// Runs a zero-delay and a GATE_DELAY=5 instance side by side.
module tb_one_bit_adder;

  logic clk;
  logic reset;
  logic run;
  int   checks;
  int   errors;

  logic [1:0] exp_sc [8];
  logic [1:0] exp_pg [4];

  one_bit_adder_if bus0 ();
  one_bit_adder_if bus5 ();

  one_bit_adder #(.GATE_DELAY(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  one_bit_adder #(.GATE_DELAY(5)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5.slave)
  );

  // Half period 25 leaves room for the 15-unit settle of dut5
  always #25 if (run) clk = ~clk;

  task automatic chk(input string tag,
                     input logic [1:0] obs,
                     input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v);
    bus0.in1     = v[2];
    bus0.in2     = v[1];
    bus0.carryin = v[0];
    bus5.in1     = v[2];
    bus5.in2     = v[1];
    bus5.carryin = v[0];
  endtask

  function automatic logic [1:0] comb0();
    return {bus0.sum, bus0.carryout};
  endfunction

  function automatic logic [1:0] comb5();
    return {bus5.sum, bus5.carryout};
  endfunction

  function automatic logic [1:0] reg0();
    return {bus0.sum_q, bus0.carryout_q};
  endfunction

  function automatic logic [1:0] reg5();
    return {bus5.sum_q, bus5.carryout_q};
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    run    = 1'b0;
    reset  = 1'b0;
    // {sum,co} indexed by {in1,in2,ci}
    exp_sc = '{2'b00, 2'b10, 2'b10, 2'b01,
               2'b10, 2'b01, 2'b01, 2'b11};
    // {prop,gen} indexed by {in1,in2}
    exp_pg = '{2'b00, 2'b10, 2'b10, 2'b01};

    // Combinational, clock stopped
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      drive(v);
      #20;
      chk($sformatf("comb0_%b", v), comb0(), exp_sc[i]);
      chk($sformatf("comb5_%b", v), comb5(), exp_sc[i]);
      chk($sformatf("pg0_%b", v),
          {bus0.prop, bus0.gen}, exp_pg[i >> 1]);
      chk($sformatf("pg5_%b", v),
          {bus5.prop, bus5.gen}, exp_pg[i >> 1]);
    end

    // Reset with 111 on the inputs
    run = 1'b1;
    @(negedge clk);
    drive(3'b111);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_q0", reg0(), 2'b00);
    chk("rst_q5", reg5(), 2'b00);
    chk("rst_comb0", comb0(), 2'b11);
    @(negedge clk);
    chk("rst_comb5", comb5(), 2'b11);

    // Latency: 110 applied, no change before the edge
    reset = 1'b0;
    drive(3'b110);
    #20;
    chk("lat_pre0", reg0(), 2'b00);
    chk("lat_pre5", reg5(), 2'b00);
    @(posedge clk);
    #1;
    chk("lat_post0", reg0(), 2'b01);
    chk("lat_post5", reg5(), 2'b01);

    // Reset mid-stream wins over new data
    @(negedge clk);
    drive(3'b100);
    @(posedge clk);
    #1;
    chk("mid_100_0", reg0(), 2'b10);
    chk("mid_100_5", reg5(), 2'b10);
    @(negedge clk);
    drive(3'b111);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst0", reg0(), 2'b00);
    chk("mid_rst5", reg5(), 2'b00);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rel0", reg0(), 2'b11);
    chk("mid_rel5", reg5(), 2'b11);

    // Reset is never asynchronous
    @(negedge clk);
    reset = 1'b1;
    #10;
    chk("sync_hold0", reg0(), 2'b11);
    chk("sync_hold5", reg5(), 2'b11);
    @(posedge clk);
    #1;
    chk("sync_clr0", reg0(), 2'b00);

    // Back-to-back stream, one result per cycle
    @(negedge clk);
    reset = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      logic [2:0] v;
      v = 3'(i);
      drive(v);
      @(posedge clk);
      #1;
      chk($sformatf("strm0_%b", v), reg0(), exp_sc[i]);
      chk($sformatf("strm5_%b", v), reg5(), exp_sc[i]);
      @(negedge clk);
    end

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
